// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: state encoding and framing constants for the program loader
package prog_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] LEN_HI_MASK   = 8'hFC;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: framed byte stream to 16-bit program memory writes, holds CPU in reset until checksum OK
import prog_loader_pkg::*;

module prog_loader #(
  parameter int         ADDR_W    = 10,
  parameter int         DATA_W    = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);
  state_t              r_state, w_next;
  logic                r_en;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wd;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W-1:0]   r_cnt;
  logic [9:0]          r_len;
  logic [7:0]          r_hi;
  logic [7:0]          r_ck;
  logic                w_hs;
  logic                w_sync;
  logic                w_bad_len;
  logic                w_last;
  logic                w_ck_ok;
  assign in_ready  = r_en & ~r_we;
  assign w_hs      = in_valid & in_ready;
  assign w_sync    = in_data == SYNC_BYTE;
  assign w_bad_len = |(in_data & LEN_HI_MASK);
  assign w_last    = r_cnt == ADDR_W'(r_len - 10'd1);
  assign w_ck_ok   = in_data == r_ck;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wd    = r_wd;
  assign cpu_reset = r_cpu_rst;
  assign load_done = r_done;
  assign load_err  = r_err;
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // next state: every transition is gated by an accepted byte
  always_comb begin
    w_next = r_state;
    if (w_hs) begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: w_next = w_sync ? S_LEN_HI : r_state;
        S_LEN_HI:              w_next = w_bad_len ? S_ERR : S_LEN_LO;
        S_LEN_LO:              w_next = |{r_len[9:8], in_data} ? S_DATA_HI : S_CKSUM;
        S_DATA_HI:             w_next = S_DATA_LO;
        S_DATA_LO:             w_next = w_last ? S_CKSUM : S_DATA_HI;
        S_CKSUM:               w_next = w_ck_ok ? S_DONE : S_ERR;
        default:               w_next = S_IDLE;
      endcase
    end
  end
  // datapath: length, word index, xor accumulator, write strobe and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wd      <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_hi      <= '0;
      r_ck      <= '0;
    end else begin
      r_en <= 1'b1;
      r_we <= 1'b0;
      if (w_hs) begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (w_sync) begin
              r_cpu_rst <= 1'b1;
              r_done    <= 1'b0;
              r_err     <= 1'b0;
              r_cnt     <= '0;
              r_ck      <= '0;
            end
          end
          S_LEN_HI: begin
            r_len[9:8] <= in_data[1:0];
            if (w_bad_len) r_err <= 1'b1;
          end
          S_LEN_LO: r_len[7:0] <= in_data;
          S_DATA_HI: begin
            r_hi <= in_data;
            r_ck <= r_ck ^ in_data;
          end
          S_DATA_LO: begin
            r_we   <= 1'b1;
            r_addr <= r_cnt;
            r_wd   <= DATA_W'({r_hi, in_data});
            r_cnt  <= r_cnt + ADDR_W'(1);
            r_ck   <= r_ck ^ in_data;
          end
          S_CKSUM: begin
            if (w_ck_ok) begin
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table vectors, corner sequences and random frames checked against a frame-parsing model
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wd;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;

  prog_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          rdy_viol = 0;
  int          stalls = 0;
  bit          chk_rdy = 1'b0;
  logic [25:0] obs[$];
  logic [25:0] exp_w[$];
  logic [7:0]  fr[$];
  bit          exp_done;
  bit          exp_err;

  typedef struct {
    int          n;
    logic [127:0] b;
    bit          done;
    bit          err;
    int          nw;
    logic [25:0] last;
  } vec_t;
  vec_t vt[7];

  always @(negedge clk) begin
    if (mem_we) obs.push_back({mem_addr, mem_wd});
    if (chk_rdy && in_ready !== !mem_we) rdy_viol++;
    if (mem_we && !in_ready) stalls++;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL handshake_timeout: byte %0h never accepted", b);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle(int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Reference: find the SYNC, read length, pair data bytes into words, xor data bytes, compare checksum
  function automatic void model();
    int i = 0;
    int n;
    logic [7:0] x = 8'h00;
    exp_w.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    while (i < fr.size() && fr[i] != 8'hA5) i++;
    if (i + 2 >= fr.size()) return;
    if (fr[i+1] > 8'd3) begin
      exp_err = 1'b1;
      return;
    end
    n = fr[i+1] * 256 + fr[i+2];
    for (int k = 0; k < n; k++) begin
      exp_w.push_back({10'(k), fr[i+3+2*k], fr[i+4+2*k]});
      x = x ^ fr[i+3+2*k] ^ fr[i+4+2*k];
    end
    exp_done = fr[i+3+2*n] == x;
    exp_err  = !exp_done;
  endfunction

  task automatic run_frame(int gap, int start);
    int mism = 0;
    obs.delete();
    for (int i = start; i < fr.size(); i++) begin
      if (gap > 0 && $urandom_range(0, gap) != 0) idle($urandom_range(1, 3));
      send(fr[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    model();
    check("load_done", load_done, exp_done);
    check("load_err", load_err, exp_err);
    check("cpu_reset", cpu_reset, !exp_done);
    check("write_count", obs.size(), exp_w.size());
    foreach (exp_w[k]) if (k >= obs.size() || obs[k] !== exp_w[k]) mism++;
    check("write_contents", mism, 0);
  endtask

  task automatic rand_frame(int n, bit bad_len, bit bad_ck);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    fr.delete();
    fr.push_back(8'hA5);
    if (bad_len) begin
      fr.push_back(8'($urandom_range(4, 255)));
      fr.push_back(8'($urandom));
      return;
    end
    fr.push_back(8'(n / 256));
    fr.push_back(8'(n % 256));
    for (int k = 0; k < 2 * n; k++) begin
      b = 8'($urandom);
      fr.push_back(b);
      x ^= b;
    end
    fr.push_back(bad_ck ? x ^ 8'($urandom_range(1, 255)) : x);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    logic [127:0] bb;
    vt[0] = '{8, 128'hA5000212_34ABCD40, 1'b1, 1'b0, 2, 26'h001ABCD};
    vt[1] = '{8, 128'hA5000212_34ABCD41, 1'b0, 1'b1, 2, 26'h001ABCD};
    vt[2] = '{4, 128'hA5000000,          1'b1, 1'b0, 0, 26'h0};
    vt[3] = '{5, 128'hA5040011_22,       1'b0, 1'b1, 0, 26'h0};
    vt[4] = '{6, 128'hA50001A5_A500,     1'b1, 1'b0, 1, 26'h000A5A5};
    vt[5] = '{8, 128'h1122A500_01010203, 1'b1, 1'b0, 1, 26'h0000102};
    vt[6] = '{3, 128'hA5FC00,            1'b0, 1'b1, 0, 26'h0};

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wd", mem_wd, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    chk_rdy = 1'b1;

    send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB);
    #2;
    chk_rdy = 1'b0;
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_cpu_reset", cpu_reset, 1);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rel_in_ready", in_ready, 1);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wd", mem_wd, 0);
    chk_rdy = 1'b1;

    for (int j = 0; j < 7; j++) begin
      bb = vt[j].b;
      fr.delete();
      for (int i = 0; i < vt[j].n; i++) fr.push_back(bb[8*(vt[j].n-1-i) +: 8]);
      run_frame(j % 2, 0);
      check($sformatf("vec%0d_done", j), load_done, vt[j].done);
      check($sformatf("vec%0d_err", j), load_err, vt[j].err);
      check($sformatf("vec%0d_nw", j), obs.size(), vt[j].nw);
      if (vt[j].nw > 0) check($sformatf("vec%0d_last", j), obs[$], vt[j].last);
    end

    s0 = stalls;
    rand_frame(3, 1'b0, 1'b0);
    run_frame(0, 0);
    check("stream_stalls", stalls - s0, 3);
    check("stream_rdy_viol", rdy_viol, 0);

    for (int r = 0; r < 25; r++) begin
      rand_frame($urandom_range(0, 12), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      run_frame(r % 2 ? 2 : 0, 0);
    end

    rand_frame(2, 1'b0, 1'b0);
    run_frame(0, 0);
    rand_frame(1023, 1'b0, 1'b0);
    send(fr[0]);
    @(negedge clk);
    in_valid = 1'b0;
    check("resync_cpu_reset", cpu_reset, 1);
    check("resync_load_done", load_done, 0);
    run_frame(0, 1);
    check("big_nw", obs.size(), 1023);
    if (obs.size() > 0) check("big_last_addr", obs[$][25:16], 1022);
    check("final_rdy_viol", rdy_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
